display_scan_controller: RTL and testbench
==========================================

// Module: display_scan_controller
// PURPOSE
//  Time-multiplexes a 4-digit 7-segment display. It walks a one-hot digit-select ("vez") through
//  digits 0..3 and presents the matching 4-bit digit value. It also inserts an all-off guard gap
//  between digits to suppress ghosting.
//  Sits upstream of the active-low digit-enable inverter and the segment decoder. indicador is
//  active-high one-hot: 4'b1000 = first (leftmost) digit.
// PARAMETERS
//  SLOT_CYCLES   1000  clock cycles per digit slot, guard gap included; legal range >= 2
//  GUARD_CYCLES  50    all-off cycles at the end of each slot; legal range 0..SLOT_CYCLES-1
// PORTS
//  clock        in   1   system clock, rising edge
//  reset_n      in   1   asynchronous active-low reset
//  enable       in   1   1 = scan, 0 = display dark
//  digits_in    in   16  [15:12]=digit0 (leftmost) ... [3:0]=digit3; sampled only at frame start
//  indicador    out  4   one-hot digit select, active-high; 0000 = no digit lit
//  digit_value  out  4   value of the digit currently selected
//  frame_tick   out  1   one-cycle pulse when a new frame is captured
// BEHAVIOUR
//  - All outputs are registered. During reset: indicador=0000, digit_value=0, frame_tick=0,
//    idx=0, cnt=0, frame_buf=0, state=IDLE.
//  - FSM states:
//    IDLE : indicador=0000, cnt=0, idx=0.
//           enable=1 at edge N -> ON at edge N, frame_buf<=digits_in, frame_tick=1 for 1 cycle.
//           indicador=1000 is visible after edge N.
//    ON   : indicador=onehot(idx) (idx0->1000, idx1->0100, idx2->0010, idx3->0001),
//           digit_value=frame_buf[idx].
//           Stays SLOT_CYCLES-GUARD_CYCLES cycles, then goes to GUARD.
//           If GUARD_CYCLES=0, it skips GUARD and advances idx directly.
//    GUARD: indicador=0000; digit_value holds the previous value. Stays GUARD_CYCLES cycles,
//           then advances idx and returns to ON.
//  - idx advance: idx 3 -> 0 wraps. On a wrap, frame_buf<=digits_in and frame_tick pulses in the
//    same cycle that ON(idx0) begins.
//  - A frame is exactly 4*SLOT_CYCLES cycles. digits_in changes mid-frame are never shown until
//    the next wrap (no tearing).
//  - cnt is $clog2(SLOT_CYCLES) bits wide and resets to 0 on every state change. The terminal
//    count is compared with ==, so the counter never wraps silently.
//  - enable=0 in any state -> IDLE on the next edge and indicador=0000 after that edge. The slot
//    is abandoned; a re-enable restarts at digit 0 with a fresh capture.
//  - reset_n low mid-slot -> all outputs go to their reset values immediately (asynchronous);
//    scanning resumes only after enable is sampled high again.
//  - Simultaneous enable fall and wrap: enable wins; no capture and no frame_tick.
// CONFIGURATION
//  - Macro LEADING_ZERO_BLANK_EN.
//  - Defined: a digit idx<3 whose frame_buf value is 0 and lies left of the first nonzero digit
//    is blanked. Its ON slot drives indicador=0000 with timing unchanged.
//    Digit 3 is never blanked. The blank mask is computed once per frame at capture time.
//  - Undefined: every digit is lit in its ON slot, zeros included.
// STRUCTURE
//  - Package display_pkg holds:
//    - N_DIGITS=4 and the state encoding S_IDLE/S_ON/S_GUARD (2 bits);
//    - function onehot_sel(idx) -> 4'b1000>>idx;
//    - the digit-field slice helper.
//  - One natural sub-module: scan_slot_timer (cnt, terminal-count compare, phase_done strobe).
//    The FSM, idx, frame_buf and the blank mask stay in this module.
// TESTING (bench: SLOT_CYCLES=8, GUARD_CYCLES=2)
//  1 Enable after reset with digits_in=16'h1234.
//    -> indicador 1000 for 6 cycles, 0000 for 2, 0100 for 6, 0000 for 2, ...;
//       digit_value 1,2,3,4; frame period 32 cycles.
//  2 Change digits_in to 16'h5678 mid-frame (at the digit1 slot).
//    -> digits 2,3 still show 3,4; the next frame shows 5,6,7,8 and frame_tick pulses with
//       indicador=1000.
//  3 Drop enable during the digit2 ON slot, then re-enable 5 cycles later.
//    -> indicador=0000 one edge after the drop; restart at 1000 with a new capture.
//  4 Assert reset_n low asynchronously mid-GUARD.
//    -> indicador=0000, digit_value=0, frame_tick=0 immediately; IDLE after release.
//  5 Build with GUARD_CYCLES=0 -> indicador never reads 0000 while enabled; 8 cycles per digit.
//  6 Build with LEADING_ZERO_BLANK_EN, digits_in=16'h0070.
//    -> digits 0,1 slots show 0000; digit2 lit with value 7; digit3 lit with value 0;
//       16'h0000 lights only digit3.

Source files
------------

// File: rtl/display_pkg.sv
// Shared definitions for the 4-digit display scan controller:
// digit count, FSM state encoding, digit-select and digit-field helpers.
package display_pkg;

  localparam int N_DIGITS = 4;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ON    = 2'd1,
    S_GUARD = 2'd2
  } state_t;

  // Digit 0 is the leftmost position and maps to the MSB of the select.
  function automatic logic [3:0] onehot_sel(input logic [1:0] idx);
    return 4'b1000 >> idx;
  endfunction

  // Digit 0 lives in the top nibble of the packed word.
  function automatic logic [3:0] digit_field(input logic [15:0] word, input logic [1:0] idx);
    logic [3:0] field;
    case (idx)
      2'd0:    field = word[15:12];
      2'd1:    field = word[11:8];
      2'd2:    field = word[7:4];
      default: field = word[3:0];
    endcase
    return field;
  endfunction

endpackage

// File: rtl/display_scan_controller_if.sv
// Bundle of the scan controller's data/handshake signals.
// master: the side supplying enable and digits; slave: the scan controller.
interface display_scan_controller_if;
  logic        enable;
  logic [15:0] digits_in;
  logic [3:0]  indicador;
  logic [3:0]  digit_value;
  logic        frame_tick;

  modport master (
    output enable, digits_in,
    input  indicador, digit_value, frame_tick
  );

  modport slave (
    input  enable, digits_in,
    output indicador, digit_value, frame_tick
  );
endinterface

// File: rtl/scan_slot_timer.sv
// Phase timer for the scan controller: counts cycles within the current
// phase and raises phase_done while the count equals the terminal value.
// The count restarts from zero whenever clear is asserted.
module scan_slot_timer #(
  parameter int CW = 3
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          clear,
  input  logic [CW-1:0] terminal,
  output logic          phase_done
);

  logic [CW-1:0] cnt;

  // Phase cycle counter; equality compare below means it never wraps unnoticed.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign phase_done = (cnt == terminal);

endmodule

// File: rtl/display_scan_controller.sv
// Time-multiplexed scan of a 4-digit 7-segment display with an all-off
// guard gap at the end of every digit slot. The digit word is captured
// once per frame so a mid-frame change never tears the display.
// Optional feature: define LEADING_ZERO_BLANK_EN to blank leading zero
// digits (digit 3 always stays lit).
module display_scan_controller
  import display_pkg::*;
#(
  parameter int SLOT_CYCLES  = 1000,
  parameter int GUARD_CYCLES = 50
) (
  input logic                       clock,
  input logic                       reset_n,
  display_scan_controller_if.slave  bus
);

  localparam int            CW         = $clog2(SLOT_CYCLES);
  localparam bit            HAS_GUARD  = (GUARD_CYCLES > 0);
  localparam logic [CW-1:0] ON_TERM    = CW'(SLOT_CYCLES - GUARD_CYCLES - 1);
  localparam logic [CW-1:0] GUARD_TERM = CW'(HAS_GUARD ? GUARD_CYCLES - 1 : 0);

  state_t        state_reg, state_next;
  logic [1:0]    idx_reg, idx_next;
  logic [15:0]   frame_buf_reg, frame_buf_next;
  logic [3:0]    blank_reg, blank_next;
  logic [3:0]    indicador_reg, indicador_next;
  logic [3:0]    value_reg, value_next;
  logic          tick_reg, tick_next;
  logic [3:0]    capture_blank;
  logic          capture, advance, clear, phase_done;
  logic [CW-1:0] terminal;

`ifdef LEADING_ZERO_BLANK_EN
  // A digit is blanked while every digit to its left (and itself) is zero.
  always_comb begin
    capture_blank    = 4'b0000;
    capture_blank[0] = (digit_field(bus.digits_in, 2'd0) == 4'd0);
    capture_blank[1] = capture_blank[0] && (digit_field(bus.digits_in, 2'd1) == 4'd0);
    capture_blank[2] = capture_blank[1] && (digit_field(bus.digits_in, 2'd2) == 4'd0);
  end
`else
  assign capture_blank = 4'b0000;
`endif

  // Next state, frame capture and next registered outputs.
  always_comb begin
    state_next     = state_reg;
    idx_next       = idx_reg;
    frame_buf_next = frame_buf_reg;
    blank_next     = blank_reg;
    indicador_next = indicador_reg;
    value_next     = value_reg;
    tick_next      = 1'b0;
    capture        = 1'b0;
    advance        = 1'b0;

    if (!bus.enable) begin
      // Disable wins over everything, including a simultaneous wrap.
      state_next     = S_IDLE;
      idx_next       = 2'd0;
      indicador_next = 4'b0000;
    end else begin
      case (state_reg)
        S_IDLE: begin
          capture = 1'b1;
        end
        S_ON: begin
          if (phase_done) begin
            if (HAS_GUARD) begin
              state_next     = S_GUARD;
              indicador_next = 4'b0000;
            end else begin
              advance = 1'b1;
            end
          end
        end
        S_GUARD: begin
          if (phase_done) begin
            advance = 1'b1;
          end
        end
        default: state_next = S_IDLE;
      endcase
    end

    if (advance) begin
      idx_next = idx_reg + 2'd1;
      capture  = (idx_reg == 2'd3);
    end

    if (capture) begin
      idx_next       = 2'd0;
      frame_buf_next = bus.digits_in;
      blank_next     = capture_blank;
      tick_next      = 1'b1;
    end

    if (capture || advance) begin
      state_next     = S_ON;
      indicador_next = blank_next[idx_next] ? 4'b0000 : onehot_sel(idx_next);
      value_next     = digit_field(frame_buf_next, idx_next);
    end

    clear    = (state_next != state_reg) || advance || (state_reg == S_IDLE);
    terminal = (state_reg == S_GUARD) ? GUARD_TERM : ON_TERM;
  end

  // State, scan position, captured frame and registered outputs.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_reg     <= S_IDLE;
      idx_reg       <= 2'd0;
      frame_buf_reg <= 16'h0000;
      blank_reg     <= 4'b0000;
      indicador_reg <= 4'b0000;
      value_reg     <= 4'd0;
      tick_reg      <= 1'b0;
    end else begin
      state_reg     <= state_next;
      idx_reg       <= idx_next;
      frame_buf_reg <= frame_buf_next;
      blank_reg     <= blank_next;
      indicador_reg <= indicador_next;
      value_reg     <= value_next;
      tick_reg      <= tick_next;
    end
  end

  scan_slot_timer #(
    .CW (CW)
  ) u_timer (
    .clock      (clock),
    .reset_n    (reset_n),
    .clear      (clear),
    .terminal   (terminal),
    .phase_done (phase_done)
  );

  assign bus.indicador   = indicador_reg;
  assign bus.digit_value = value_reg;
  assign bus.frame_tick  = tick_reg;

endmodule

// File: tb/tb_display_scan_controller.sv
// Bench for display_scan_controller: one instance with an 8-cycle slot and
// 2-cycle guard, one with no guard. Both share stimulus and are checked
// against a time-slot model (frame position -> expected outputs).
module tb_display_scan_controller;

  logic        clock   = 1'b0;
  logic        reset_n = 1'b1;
  logic        enable  = 1'b0;
  logic [15:0] digits  = 16'h0000;

  display_scan_controller_if bus0();
  display_scan_controller_if bus1();

  assign bus0.enable    = enable;
  assign bus0.digits_in = digits;
  assign bus1.enable    = enable;
  assign bus1.digits_in = digits;

  display_scan_controller #(.SLOT_CYCLES(8), .GUARD_CYCLES(2)) dut_guard (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus0)
  );

  display_scan_controller #(.SLOT_CYCLES(8), .GUARD_CYCLES(0)) dut_noguard (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus1)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;

  // model state per instance
  int          slot_c[2]  = '{8, 8};
  int          guard_c[2] = '{2, 0};
  bit          running[2];
  int          t[2];
  logic [15:0] frame[2];
  logic [3:0]  exp_ind[2];
  logic [3:0]  exp_val[2];
  logic        exp_tick[2];
  bit          val_chk[2];

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s at %0t: got=%h want=%h", tag, $time, got, want);
    end
  endtask

  function automatic logic [3:0] nibble(input logic [15:0] w, input int d);
    return 4'(w >> (12 - 4 * d));
  endfunction

  function automatic bit is_blank(input logic [15:0] w, input int d);
`ifdef LEADING_ZERO_BLANK_EN
    int first = 4;
    for (int i = 3; i >= 0; i--) begin
      if (nibble(w, i) != 4'd0) first = i;
    end
    return (d < 3) && (d < first);
`else
    return 1'b0;
`endif
  endfunction

  task automatic model_reset(input int k);
    running[k]  = 1'b0;
    exp_ind[k]  = 4'b0000;
    exp_val[k]  = 4'd0;
    exp_tick[k] = 1'b0;
    val_chk[k]  = 1'b1;
  endtask

  // Expected outputs after one rising edge, from frame position alone.
  task automatic model_edge(input int k);
    int d;
    int pos;
    logic [3:0] oh;
    if (!reset_n) begin
      model_reset(k);
      return;
    end
    exp_tick[k] = 1'b0;
    if (!enable) begin
      running[k] = 1'b0;
      exp_ind[k] = 4'b0000;
      val_chk[k] = 1'b0;
      return;
    end
    if (!running[k]) begin
      running[k] = 1'b1;
      t[k] = 0;
    end else begin
      t[k] = (t[k] + 1) % (4 * slot_c[k]);
    end
    if (t[k] == 0) begin
      frame[k]    = digits;
      exp_tick[k] = 1'b1;
      if (k == 0) $display("frame captured: digits=%h at %0t", digits, $time);
    end
    d   = t[k] / slot_c[k];
    pos = t[k] % slot_c[k];
    oh  = 4'b1000 >> d;
    if (pos < slot_c[k] - guard_c[k]) begin
      exp_ind[k] = is_blank(frame[k], d) ? 4'b0000 : oh;
      exp_val[k] = nibble(frame[k], d);
      val_chk[k] = 1'b1;
    end else begin
      exp_ind[k] = 4'b0000;
      val_chk[k] = 1'b0;
    end
  endtask

  task automatic compare();
    check("g_ind", {12'h000, bus0.indicador}, {12'h000, exp_ind[0]});
    check("g_tick", {15'h0000, bus0.frame_tick}, {15'h0000, exp_tick[0]});
    if (val_chk[0]) check("g_val", {12'h000, bus0.digit_value}, {12'h000, exp_val[0]});
    check("n_ind", {12'h000, bus1.indicador}, {12'h000, exp_ind[1]});
    check("n_tick", {15'h0000, bus1.frame_tick}, {15'h0000, exp_tick[1]});
    if (val_chk[1]) check("n_val", {12'h000, bus1.digit_value}, {12'h000, exp_val[1]});
  endtask

  task automatic tick();
    @(posedge clock);
    model_edge(0);
    model_edge(1);
    #1;
    compare();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Advance until the guarded instance sits at a given frame position.
  task automatic wait_pos(input int target);
    int n = 0;
    while (!(running[0] && t[0] == target) && n < 200) begin
      tick();
      n++;
    end
    check("wait_pos", {15'h0000, (n < 200)}, 16'h0001);
  endtask

  initial begin
    logic [15:0] d;
    int z;

    // reset state
    #1 reset_n = 1'b0;
    #1;
    model_reset(0);
    model_reset(1);
    compare();
    run(2);
    #2 reset_n = 1'b1;
    run(2);

    // scan 1234, then change to 5678 during digit1 slot
    digits = 16'h1234;
    enable = 1'b1;
    wait_pos(9);
    digits = 16'h5678;
    run(40);

    // leading-zero patterns
    digits = 16'h0070;
    wait_pos(0);
    run(32);
    digits = 16'h0000;
    run(40);

    // drop enable during digit2 ON slot, re-enable 5 cycles later
    digits = 16'h9abc;
    wait_pos(17);
    enable = 1'b0;
    run(5);
    enable = 1'b1;
    run(40);

    // asynchronous reset during first guard cycle
    wait_pos(6);
    #3 reset_n = 1'b0;
    #1;
    model_reset(0);
    model_reset(1);
    compare();
    run(2);
    #2 reset_n = 1'b1;
    run(40);

    // randomized enable drops and digit changes with leading zeros
    for (int i = 0; i < 800; i++) begin
      if (enable && $urandom_range(0, 99) < 3) enable = 1'b0;
      else if (!enable && $urandom_range(0, 99) < 40) enable = 1'b1;
      if ($urandom_range(0, 9) == 0) begin
        d = 16'($urandom);
        z = $urandom_range(0, 4);
        digits = d >> (4 * z);
      end
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
